ro_freq_meter: RTL and testbench

Parametrised measurement front-end for the ring-oscillator lattice. It enables a selectable set of N_CH oscillator outputs and waits a settle time. It then counts the rising edges of each oscillator over a programmable gate window of system-clock cycles. Per-channel counts are returned one at a time over a valid/ready stream, replacing open-loop free-running simulation with a synthesisable, self-timed frequency readout.

---
 rtl/ro_meter_pkg.sv | 22 ++
 rtl/ro_edge_counter.sv | 48 ++++
 rtl/ro_freq_meter.sv | 131 +++++++++++++
 tb/tb_ro_freq_meter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meter_pkg.sv
// rtl/ro_meter_pkg.sv - shared types and constants for the ring-oscillator frequency meter
package ro_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    localparam int SYNC_STAGES_MIN   = 2;
    localparam int DEF_N_CH          = 8;
    localparam int DEF_CNT_W         = 24;
    localparam int DEF_GATE_W        = 24;
    localparam int DEF_SETTLE_CYCLES = 16;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronised rising-edge counter with saturation and sticky overflow
module ro_edge_counter
    import ro_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int STG = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STG-1:0] sync_q;
    logic           prev_q;
    logic           edge_det;

    assign edge_det = sync_q[STG-1] & ~prev_q;

    // prev_q is not cleared with the counter so a level already high at gate start is not a fake edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STG-2:0], ro_in};
            prev_q <= sync_q[STG-1];
            if (clear) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (count_en && edge_det) begin
                if (&count) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - gated ring-oscillator frequency meter with streamed per-channel results
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SYNC_STAGES   = SYNC_STAGES_MIN,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [GATE_W-1:0]         gate_len,
    input  logic [N_CH-1:0]           ch_mask,
    input  logic [N_CH-1:0]           ro_in,
    output logic [N_CH-1:0]           ro_en,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ch_idx_w(N_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]          res_count,
    output logic                      res_ovf,
    output logic                      done
);

    localparam int CH_W  = ch_idx_w(N_CH);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

    state_t            state, state_nx;
    logic [N_CH-1:0]   mask_q, rem_q, rem_clr;
    logic [GATE_W-1:0] gate_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [CH_W-1:0]   sel;
    logic              clear, gate_on;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [N_CH-1:0]   ovf;

    assign gate_on = (state == ST_GATE);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ro_edge_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .ro_in    (ro_in[g]),
            .clear    (clear),
            .count_en (gate_on & mask_q[g]),
            .count    (cnt[g]),
            .ovf      (ovf[g])
        );
    end

    // lowest still-pending channel is presented first
    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rem_q[i]) sel = CH_W'(i);
        end
        rem_clr = rem_q & ~(N_CH'(1) << sel);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_SETTLE;
            ST_SETTLE: begin
                if (mask_q == '0) begin
                    state_nx = ST_FINISH;
                end else if (tmr_q == '0) begin
                    state_nx = ST_GATE;
                    clear    = 1'b1;
                end
            end
            ST_GATE:   if (tmr_q == '0) state_nx = ST_DRAIN;
            ST_DRAIN:  if (res_ready && rem_clr == '0) state_nx = ST_FINISH;
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // tmr_q is reused as the settle timer and then as the gate timer
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            rem_q  <= '0;
            gate_q <= '0;
            tmr_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mask_q <= ch_mask;
                        gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                        tmr_q  <= TMR_W'(SETTLE_CYCLES - 1);
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == '0) tmr_q <= TMR_W'(gate_q) - 1'b1;
                    else             tmr_q <= tmr_q - 1'b1;
                end
                ST_GATE: begin
                    if (tmr_q == '0) rem_q <= mask_q;
                    else             tmr_q <= tmr_q - 1'b1;
                end
                ST_DRAIN: begin
                    if (res_ready) rem_q <= rem_clr;
                end
                default: ;
            endcase
        end
    end

    assign ro_en     = (state == ST_SETTLE || state == ST_GATE) ? mask_q : '0;
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_DRAIN);
    assign res_ch    = res_valid ? sel : '0;
    assign res_count = res_valid ? cnt[sel] : '0;
    assign res_ovf   = res_valid ? ovf[sel] : 1'b0;
    assign done      = (state == ST_FINISH);

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - self-checking bench for ro_freq_meter
`timescale 1ns/1ps
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] gate_len;
    logic [7:0]  ch_mask;
    logic [7:0]  ro_in;
    logic        res_ready;

    logic [7:0]  ro_en, ro_en4;
    logic        busy, busy4, res_valid, res_valid4, res_ovf, res_ovf4, done, done4;
    logic [2:0]  res_ch, res_ch4;
    logic [23:0] res_count;
    logic [3:0]  res_count4;

    int per [8];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 8; gi++) begin : g_ro
        logic r = 1'b0;
        assign ro_in[gi] = r;
        initial begin
            #1;
            forever begin
                #(per[gi] / 2);
                r = ~r;
            end
        end
    end

    ro_freq_meter dut (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .ch_mask(ch_mask),
        .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_ch(res_ch), .res_count(res_count),
        .res_ovf(res_ovf), .done(done)
    );

    ro_freq_meter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .ch_mask(ch_mask),
        .ro_in(ro_in), .ro_en(ro_en4), .busy(busy4), .res_valid(res_valid4),
        .res_ready(res_ready), .res_ch(res_ch4), .res_count(res_count4),
        .res_ovf(res_ovf4), .done(done4)
    );

    typedef struct {
        logic [7:0] mask;
        int         gate;
        int         ready_pct;
        bit         poke;
        int         exp_lat;
        int         exp_nres;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input longint act, input longint ideal_x10);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected about %0d.%0d", name, act, ideal_x10 / 10, ideal_x10 % 10);
        end
    endtask

    // true edge count in a window of g clk cycles is floor or ceil of g*10/p
    function automatic bit cnt_ok(input longint cnt, input int p, input int g);
        longint d;
        d = cnt * p - longint'(g) * 10;
        return (d > -p) && (d < p);
    endfunction

    task automatic run_case(input vec_t v);
        int n, first_v, nres, nres4, done_at, last_hs, n_done, budget, g, p, exp_ch;
        int bad_busy, bad_stab, bad_roen;
        logic [7:0]  rem;
        bit          stall;
        logic [2:0]  p_ch;
        logic [23:0] p_cnt;
        logic        p_ovf;
        longint      t;

        g = (v.gate == 0) ? 1 : v.gate;
        t = longint'(g) * 10;
        first_v = -1; done_at = -1; last_hs = -1;
        nres = 0; nres4 = 0; n_done = 0;
        bad_busy = 0; bad_stab = 0; bad_roen = 0;
        stall = 1'b0; p_ch = '0; p_cnt = '0; p_ovf = 1'b0;
        rem = v.mask;
        budget = 400 + g + 60 * 8;

        gate_len = 24'(v.gate); ch_mask = v.mask; res_ready = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; n = 1;

        while (n < budget) begin
            if (v.poke && n == 1) begin
                start = 1'b1; ch_mask = 8'hFF; gate_len = 24'd5;
            end else if (v.poke && n == 2) begin
                start = 1'b0; ch_mask = v.mask; gate_len = 24'(v.gate);
            end
            if (v.ready_pct < 0) res_ready = (first_v >= 0 && n >= first_v + 20);
            else                 res_ready = ($urandom_range(0, 99) < v.ready_pct);
            #1;

            if (n == 1) chk("ro_en_cycle1", ro_en, v.mask);
            if (v.mask != 0 && n == v.exp_lat - 1) chk("ro_en_last_gate", ro_en, v.mask);
            if (res_valid && ro_en != 0) bad_roen++;
            if (stall && (!res_valid || res_ch != p_ch || res_count != p_cnt || res_ovf != p_ovf))
                bad_stab++;
            if (res_valid && first_v < 0) first_v = n;

            if (res_valid && res_ready) begin
                exp_ch = -1;
                for (int i = 7; i >= 0; i--) if (rem[i]) exp_ch = i;
                chk("res_ch_order", res_ch, exp_ch);
                if (exp_ch >= 0) begin
                    p = per[exp_ch];
                    chk_ok("res_count", cnt_ok(res_count, p, g), res_count, t * 10 / p);
                    chk("res_ovf", res_ovf, 0);
                    rem[exp_ch] = 1'b0;
                end
                nres++;
                last_hs = n;
            end

            if (res_valid4 && res_ready) begin
                p = per[res_ch4];
                if (t >= 16 * p) begin
                    chk("cnt4_sat", res_count4, 15);
                    chk("ovf4_set", res_ovf4, 1);
                end else if (t <= 15 * p) begin
                    chk_ok("cnt4_count", cnt_ok(res_count4, p, g), res_count4, t * 10 / p);
                    chk("ovf4_clear", res_ovf4, 0);
                end
                nres4++;
            end

            stall = res_valid && !res_ready;
            p_ch = res_ch; p_cnt = res_count; p_ovf = res_ovf;

            if (done) begin
                n_done++;
                if (done_at < 0) done_at = n;
            end
            if (done_at < 0 && !busy) bad_busy++;
            if (done_at >= 0 && n == done_at + 1) begin
                chk("busy_after_done", busy, 0);
                break;
            end
            @(posedge clk); #1; n++;
        end

        chk("first_valid_cycle", first_v, v.exp_lat);
        chk("num_results", nres, v.exp_nres);
        chk("num_results_w4", nres4, v.exp_nres);
        chk("done_cycle", done_at, (v.exp_nres == 0) ? 2 : last_hs + 1);
        chk("done_pulses", n_done, 1);
        chk("busy_low_early", bad_busy, 0);
        chk("res_unstable", bad_stab, 0);
        chk("ro_en_in_drain", bad_roen, 0);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t rv;
        int bad;

        per = '{80, 40, 60, 200, 100, 30, 150, 50};
        vecs[0] = '{8'h09, 1000, 100, 1'b0, 1017, 2};
        vecs[1] = '{8'h01, 100,  100, 1'b0, 117,  1};
        vecs[2] = '{8'h02, 200,  100, 1'b0, 217,  1};
        vecs[3] = '{8'h2C, 150,  -1,  1'b0, 167,  3};
        vecs[4] = '{8'h00, 50,   100, 1'b1, -1,   0};
        vecs[5] = '{8'h80, 0,    100, 1'b1, 18,   1};
        vecs[6] = '{8'hFF, 40,   50,  1'b1, 57,   8};

        rst = 1'b1; start = 1'b0; gate_len = '0; ch_mask = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ro_en", ro_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_ch", res_ch, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run_case(vecs[i]);

        gate_len = 24'd300; ch_mask = 8'h07;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (59) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_ro_en", ro_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_done", done, 0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy || res_valid) bad++;
        end
        chk("midrst_quiet", bad, 0);
        run_case(vecs[1]);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8; i++) per[i] = 10 * $urandom_range(3, 40);
            repeat (50) @(posedge clk);
            rv.mask      = 8'($urandom_range(0, 255));
            rv.gate      = $urandom_range(0, 300);
            rv.ready_pct = $urandom_range(20, 100);
            rv.poke      = 1'($urandom_range(0, 1));
            rv.exp_lat   = (rv.mask == 0) ? -1 : 17 + ((rv.gate == 0) ? 1 : rv.gate);
            rv.exp_nres  = $countones(rv.mask);
            run_case(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
